// File: rtl/sched_pkg.sv
// Shared opcode constants, scheduler state enum and decoded-instruction fields for the issue scheduler.
package sched_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BLOCKED = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       is_load;
        logic       is_mem;
        logic       is_ctrl;
    } dec_t;

    function automatic dec_t decode_ins(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] op;
        op          = ins[6:0];
        d.rd        = ins[11:7];
        d.rs1       = ins[19:15];
        d.rs2       = ins[24:20];
        d.uses_rs1  = !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
        d.uses_rs2  = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
        d.writes_rd = ((op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_LUI) ||
                       (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR)) && (ins[11:7] != 5'd0);
        d.is_load   = (op == OP_LOAD);
        d.is_mem    = (op == OP_LOAD) || (op == OP_STORE);
        d.is_ctrl   = (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
        return d;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Load-latency scoreboard: one countdown per architectural register, busy while nonzero.
module issue_scoreboard
    import sched_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en0,
    input  logic [4:0] set_rd0,
    input  logic       set_en1,
    input  logic [4:0] set_rd1,
    input  logic [4:0] qry_rs0,
    input  logic [4:0] qry_rs1,
    input  logic [4:0] qry_rs2,
    input  logic [4:0] qry_rs3,
    output logic       busy0,
    output logic       busy1,
    output logic       busy2,
    output logic       busy3
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LOAD_LAT);

    logic [CNT_W-1:0] r_cnt [32];

    // Per-register countdown; a new load on the same register overrides the decrement
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (reset) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end else if ((set_en0 && (set_rd0 == 5'(i))) || (set_en1 && (set_rd1 == 5'(i)))) begin
                r_cnt[i] <= LAT_INIT;
            end else if (r_cnt[i] != {CNT_W{1'b0}}) begin
                r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end else begin
                r_cnt[i] <= r_cnt[i];
            end
        end
    end

    assign busy0 = (qry_rs0 != 5'd0) && (r_cnt[qry_rs0] != {CNT_W{1'b0}});
    assign busy1 = (qry_rs1 != 5'd0) && (r_cnt[qry_rs1] != {CNT_W{1'b0}});
    assign busy2 = (qry_rs2 != 5'd0) && (r_cnt[qry_rs2] != {CNT_W{1'b0}});
    assign busy3 = (qry_rs3 != 5'd0) && (r_cnt[qry_rs3] != {CNT_W{1'b0}});

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler for an RV32I queue head pair with load-use scoreboard.
// Optional SCHED_STATS_EN adds saturating dual/split/stall event counters.
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        q_valid0,
    input  logic        q_valid1,
    input  logic [31:0] q_ins0,
    input  logic [31:0] q_ins1,
    input  logic        hold,
    input  logic        flush,
    output logic [1:0]  q_pop,
    output logic        dp1_valid,
    output logic [31:0] dp1_ins,
    output logic        dp2_valid,
    output logic [31:0] dp2_ins,
    output logic [1:0]  sched_state
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] dual_cnt,
    output logic [15:0] split_cnt,
    output logic [15:0] stall_cnt
`endif
);

    dec_t         w_d0;
    dec_t         w_d1;
    logic         w_busy0_rs1;
    logic         w_busy0_rs2;
    logic         w_busy1_rs1;
    logic         w_busy1_rs2;
    logic         w_stall0;
    logic         w_stall1;
    logic         w_pair_block;
    logic         w_issue0;
    logic         w_issue1;
    logic         w_unused;
    sched_state_e r_state;
    sched_state_e w_state_next;
    logic         r_dp1_valid;
    logic [31:0]  r_dp1_ins;
    logic         r_dp2_valid;
    logic [31:0]  r_dp2_ins;

    assign w_d0     = decode_ins(q_ins0);
    assign w_d1     = decode_ins(q_ins1);
    assign w_unused = w_d1.is_ctrl;

    issue_scoreboard #(
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en0 (w_issue0 && w_d0.is_load && w_d0.writes_rd),
        .set_rd0 (w_d0.rd),
        .set_en1 (w_issue1 && w_d1.is_load && w_d1.writes_rd),
        .set_rd1 (w_d1.rd),
        .qry_rs0 (w_d0.rs1),
        .qry_rs1 (w_d0.rs2),
        .qry_rs2 (w_d1.rs1),
        .qry_rs3 (w_d1.rs2),
        .busy0   (w_busy0_rs1),
        .busy1   (w_busy0_rs2),
        .busy2   (w_busy1_rs1),
        .busy3   (w_busy1_rs2)
    );

    // Issue decision: scoreboard stalls plus intra-pair hazards and structural limits
    always_comb begin
        w_stall0 = (w_d0.uses_rs1 && w_busy0_rs1) || (w_d0.uses_rs2 && w_busy0_rs2);
        w_stall1 = (w_d1.uses_rs1 && w_busy1_rs1) || (w_d1.uses_rs2 && w_busy1_rs2);
        w_pair_block = (w_d0.writes_rd && ((w_d1.uses_rs1 && (w_d1.rs1 == w_d0.rd)) ||
                                           (w_d1.uses_rs2 && (w_d1.rs2 == w_d0.rd))))
                     || (w_d0.writes_rd && w_d1.writes_rd && (w_d0.rd == w_d1.rd))
                     || (w_d0.is_mem && w_d1.is_mem)
                     || w_d0.is_ctrl;
        w_issue0 = q_valid0 && !hold && !flush && !reset && !w_stall0;
        w_issue1 = w_issue0 && q_valid1 && !w_stall1 && !w_pair_block;
        q_pop    = {1'b0, w_issue0} + {1'b0, w_issue1};
    end

    // Next-state: hold and flush freeze the observed state
    always_comb begin
        w_state_next = r_state;
        if (hold || flush) begin
            w_state_next = r_state;
        end else if (!q_valid0) begin
            w_state_next = ST_IDLE;
        end else if (w_stall0) begin
            w_state_next = ST_BLOCKED;
        end else begin
            w_state_next = ST_ISSUE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue registers: flush clears, hold freezes, otherwise non-issued slots become NOPs
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_dp1_valid <= 1'b0;
            r_dp1_ins   <= 32'h0;
            r_dp2_valid <= 1'b0;
            r_dp2_ins   <= 32'h0;
        end else if (hold) begin
            r_dp1_valid <= r_dp1_valid;
            r_dp1_ins   <= r_dp1_ins;
            r_dp2_valid <= r_dp2_valid;
            r_dp2_ins   <= r_dp2_ins;
        end else begin
            r_dp1_valid <= w_issue0;
            r_dp1_ins   <= w_issue0 ? q_ins0 : 32'h0;
            r_dp2_valid <= w_issue1;
            r_dp2_ins   <= w_issue1 ? q_ins1 : 32'h0;
        end
    end

    assign dp1_valid   = r_dp1_valid;
    assign dp1_ins     = r_dp1_ins;
    assign dp2_valid   = r_dp2_valid;
    assign dp2_ins     = r_dp2_ins;
    assign sched_state = r_state;

`ifdef SCHED_STATS_EN
    logic [15:0] r_dual_cnt;
    logic [15:0] r_split_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dual_cnt  <= 16'h0;
            r_split_cnt <= 16'h0;
            r_stall_cnt <= 16'h0;
        end else begin
            r_dual_cnt  <= (q_pop == 2'd2) ? sat_inc16(r_dual_cnt) : r_dual_cnt;
            r_split_cnt <= ((q_pop == 2'd1) && q_valid1) ? sat_inc16(r_split_cnt) : r_split_cnt;
            r_stall_cnt <= (r_state == ST_BLOCKED) ? sat_inc16(r_stall_cnt) : r_stall_cnt;
        end
    end

    assign dual_cnt  = r_dual_cnt;
    assign split_cnt = r_split_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: vector table, directed corner sequences, random program vs reference model.
module tb_issue_scheduler;

    localparam int LOAD_LAT = 2;

    logic        clk;
    logic        reset;
    logic        q_valid0;
    logic        q_valid1;
    logic [31:0] q_ins0;
    logic [31:0] q_ins1;
    logic        hold;
    logic        flush;
    logic [1:0]  q_pop;
    logic        dp1_valid;
    logic [31:0] dp1_ins;
    logic        dp2_valid;
    logic [31:0] dp2_ins;
    logic [1:0]  sched_state;
`ifdef SCHED_STATS_EN
    logic [15:0] dual_cnt;
    logic [15:0] split_cnt;
    logic [15:0] stall_cnt;
`endif

    issue_scheduler #(.LOAD_LAT(LOAD_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .q_valid0    (q_valid0),
        .q_valid1    (q_valid1),
        .q_ins0      (q_ins0),
        .q_ins1      (q_ins1),
        .hold        (hold),
        .flush       (flush),
        .q_pop       (q_pop),
        .dp1_valid   (dp1_valid),
        .dp1_ins     (dp1_ins),
        .dp2_valid   (dp2_valid),
        .dp2_ins     (dp2_ins),
        .sched_state (sched_state)
`ifdef SCHED_STATS_EN
        ,
        .dual_cnt    (dual_cnt),
        .split_cnt   (split_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: absolute cycle at which each register becomes readable
    int          cyc = 0;
    int          ready [32];
    logic        m_v1, m_v2;
    logic [31:0] m_i1, m_i2;
    logic [1:0]  m_state;
    logic [1:0]  s_pop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] e_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] e_add(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] e_lw(input int rd, input int rs1);
        return {12'h000, 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction
    function automatic logic [31:0] e_sw(input int rs2, input int rs1);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b010, 5'h00, 7'h23};
    endfunction
    function automatic logic [31:0] e_beq(input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'h00, 7'h63};
    endfunction
    function automatic logic [31:0] e_jal(input int rd);
        return {20'h00100, 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] e_jalr(input int rd, input int rs1);
        return {12'h000, 5'(rs1), 3'b000, 5'(rd), 7'h67};
    endfunction
    function automatic logic [31:0] e_lui(input int rd);
        return {20'h12345, 5'(rd), 7'h37};
    endfunction

    function automatic logic u1(input logic [31:0] w);
        return !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
    endfunction
    function automatic logic u2(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction
    function automatic logic wr(input logic [31:0] w);
        return (w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (w[11:7] != 5'd0);
    endfunction
    function automatic logic mem(input logic [31:0] w);
        return w[6:0] inside {7'h03, 7'h23};
    endfunction
    function automatic logic ctl(input logic [31:0] w);
        return w[6:0] inside {7'h63, 7'h6F, 7'h67};
    endfunction
    function automatic logic busy(input logic [4:0] r);
        return (r != 5'd0) && (cyc < ready[r]);
    endfunction
    function automatic logic blocked(input logic [31:0] w);
        return (u1(w) && busy(w[19:15])) || (u2(w) && busy(w[24:20]));
    endfunction

    // One clock: drive, check q_pop against the model, step, check registered outputs
    task automatic run_cycle(input logic v0, input logic v1, input logic [31:0] i0, input logic [31:0] i1,
                             input logic h, input logic f, input logic rst, output int npop);
        logic iss0, iss1, st0, dep;
        q_valid0 = v0; q_valid1 = v1; q_ins0 = i0; q_ins1 = i1;
        hold = h; flush = f; reset = rst;
        #1;
        st0  = blocked(i0);
        iss0 = v0 && !h && !f && !rst && !st0;
        dep  = (wr(i0) && ((u1(i1) && (i1[19:15] == i0[11:7])) || (u2(i1) && (i1[24:20] == i0[11:7]))))
            || (wr(i0) && wr(i1) && (i0[11:7] == i1[11:7]))
            || (mem(i0) && mem(i1)) || ctl(i0);
        iss1 = iss0 && v1 && !blocked(i1) && !dep;
        npop = int'(iss0) + int'(iss1);
        s_pop = q_pop;
        check("q_pop", 32'(q_pop), 32'(npop));
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < 32; r++) ready[r] = 0;
            m_v1 = 1'b0; m_i1 = 32'h0; m_v2 = 1'b0; m_i2 = 32'h0; m_state = 2'd0;
        end else begin
            if (iss0 && (i0[6:0] == 7'h03) && wr(i0)) ready[i0[11:7]] = cyc + LOAD_LAT + 1;
            if (iss1 && (i1[6:0] == 7'h03) && wr(i1)) ready[i1[11:7]] = cyc + LOAD_LAT + 1;
            if (f) begin
                m_v1 = 1'b0; m_i1 = 32'h0; m_v2 = 1'b0; m_i2 = 32'h0;
            end else if (!h) begin
                m_v1 = iss0; m_i1 = iss0 ? i0 : 32'h0;
                m_v2 = iss1; m_i2 = iss1 ? i1 : 32'h0;
            end
            if (!h && !f) m_state = !v0 ? 2'd0 : (st0 ? 2'd2 : 2'd1);
        end
        cyc++;
        check("dp1_valid", 32'(dp1_valid), 32'(m_v1));
        check("dp1_ins", dp1_ins, m_i1);
        check("dp2_valid", 32'(dp2_valid), 32'(m_v2));
        check("dp2_ins", dp2_ins, m_i2);
        check("sched_state", 32'(sched_state), 32'(m_state));
    endtask

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        h;
        logic        f;
        int          pop;
        logic        ev1;
        logic        ev2;
    } vec_t;

    function automatic logic [31:0] rand_ins();
        int rd = int'($urandom_range(0, 7));
        int a  = int'($urandom_range(0, 7));
        int b  = int'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: return e_addi(rd, a, int'($urandom_range(0, 100)));
            1: return e_add(rd, a, b);
            2: return e_lw(rd, a);
            3: return e_sw(b, a);
            4: return e_beq(a, b);
            5: return e_jal(rd);
            6: return e_lui(rd);
            default: return e_jalr(rd, a);
        endcase
    endfunction

    vec_t        tbl [14];
    logic [31:0] prog [$];

    initial begin
        int np;
        logic v0, v1;
        reset = 1'b1; q_valid0 = 1'b0; q_valid1 = 1'b0; q_ins0 = 32'h0; q_ins1 = 32'h0;
        hold = 1'b0; flush = 1'b0;
        for (int r = 0; r < 32; r++) ready[r] = 0;
        @(posedge clk);
        #1;
        run_cycle(1'b1, 1'b1, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b0, 1'b0, 1'b1, np);
        check("reset_q_pop", 32'(s_pop), 32'd0);
        check("reset_dp1_valid", 32'(dp1_valid), 32'd0);
        check("reset_state", 32'(sched_state), 32'd0);

        tbl[0]  = '{1'b1, 1'b1, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b0, 1'b0, 2, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, e_addi(1, 0, 5), e_add(3, 1, 1), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, e_beq(1, 2), e_addi(3, 0, 1), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, e_lw(5, 0), e_sw(6, 0), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, e_addi(1, 0, 5), e_addi(1, 0, 6), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, e_addi(0, 0, 1), e_add(3, 0, 0), 1'b0, 1'b0, 2, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, e_jal(1), e_addi(2, 0, 3), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, e_add(3, 1, 2), e_lui(1), 1'b0, 1'b0, 2, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b1, 1'b0, 0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, e_sw(1, 0), e_lw(2, 0), 1'b0, 1'b0, 1, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, e_add(3, 1, 2), e_sw(3, 4), 1'b0, 1'b0, 1, 1'b1, 1'b0};

        for (int k = 0; k < 14; k++) begin
            run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, np);
            run_cycle(tbl[k].v0, tbl[k].v1, tbl[k].i0, tbl[k].i1, tbl[k].h, tbl[k].f, 1'b0, np);
            check($sformatf("tbl%0d_pop", k), 32'(s_pop), 32'(tbl[k].pop));
            check($sformatf("tbl%0d_v1", k), 32'(dp1_valid), 32'(tbl[k].ev1));
            check($sformatf("tbl%0d_v2", k), 32'(dp2_valid), 32'(tbl[k].ev2));
            check($sformatf("tbl%0d_ins1", k), dp1_ins, tbl[k].ev1 ? tbl[k].i0 : 32'h0);
            check($sformatf("tbl%0d_ins2", k), dp2_ins, tbl[k].ev2 ? tbl[k].i1 : 32'h0);
        end

        // RAW pair: consumer follows alone on the next cycle
        run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, np);
        run_cycle(1'b1, 1'b1, e_addi(1, 0, 5), e_add(3, 1, 1), 1'b0, 1'b0, 1'b0, np);
        check("raw_pop", 32'(s_pop), 32'd1);
        check("raw_dp2_valid", 32'(dp2_valid), 32'd0);
        run_cycle(1'b1, 1'b0, e_add(3, 1, 1), 32'h0, 1'b0, 1'b0, 1'b0, np);
        check("raw_follow_pop", 32'(s_pop), 32'd1);
        check("raw_follow_ins", dp1_ins, e_add(3, 1, 1));

        // Load-use: two blocked cycles, then the consumer issues
        run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, np);
        run_cycle(1'b1, 1'b1, e_lw(5, 0), e_add(6, 5, 0), 1'b0, 1'b0, 1'b0, np);
        check("lu_pop0", 32'(s_pop), 32'd1);
        for (int k = 0; k < 2; k++) begin
            run_cycle(1'b1, 1'b0, e_add(6, 5, 0), 32'h0, 1'b0, 1'b0, 1'b0, np);
            check($sformatf("lu_stall%0d_pop", k), 32'(s_pop), 32'd0);
            check($sformatf("lu_stall%0d_state", k), 32'(sched_state), 32'd2);
        end
        run_cycle(1'b1, 1'b0, e_add(6, 5, 0), 32'h0, 1'b0, 1'b0, 1'b0, np);
        check("lu_go_pop", 32'(s_pop), 32'd1);
        check("lu_go_state", 32'(sched_state), 32'd1);
        check("lu_go_ins", dp1_ins, e_add(6, 5, 0));

        // Hold freezes outputs for three cycles; flush under hold clears them
        run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, np);
        run_cycle(1'b1, 1'b1, e_addi(1, 0, 5), e_addi(2, 0, 7), 1'b0, 1'b0, 1'b0, np);
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b1, 1'b1, e_lui(3), e_lui(4), 1'b1, 1'b0, 1'b0, np);
            check($sformatf("hold%0d_pop", k), 32'(s_pop), 32'd0);
            check($sformatf("hold%0d_ins1", k), dp1_ins, e_addi(1, 0, 5));
            check($sformatf("hold%0d_ins2", k), dp2_ins, e_addi(2, 0, 7));
            check($sformatf("hold%0d_v2", k), 32'(dp2_valid), 32'd1);
        end
        run_cycle(1'b1, 1'b1, e_lui(3), e_lui(4), 1'b1, 1'b1, 1'b0, np);
        check("flush_v1", 32'(dp1_valid), 32'd0);
        check("flush_v2", 32'(dp2_valid), 32'd0);
        check("flush_ins1", dp1_ins, 32'h0);
        check("flush_state", 32'(sched_state), 32'd1);

        // Reset with a load outstanding drops its busy mark
        run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, np);
        run_cycle(1'b1, 1'b0, e_lw(5, 0), 32'h0, 1'b0, 1'b0, 1'b0, np);
        run_cycle(1'b1, 1'b0, e_add(6, 5, 0), 32'h0, 1'b0, 1'b0, 1'b1, np);
        check("rst_force_pop", 32'(s_pop), 32'd0);
        run_cycle(1'b1, 1'b0, e_add(6, 5, 0), 32'h0, 1'b0, 1'b0, 1'b0, np);
        check("rst_clear_pop", 32'(s_pop), 32'd1);
        check("rst_clear_v1", 32'(dp1_valid), 32'd1);

        // Random program drained through the scheduler
        run_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, np);
        for (int n = 0; n < 1500; n++) begin
            while (prog.size() < 4) prog.push_back(rand_ins());
            v0 = ($urandom_range(0, 9) != 0);
            v1 = v0 && ($urandom_range(0, 5) != 0);
            run_cycle(v0, v1, prog[0], prog[1], ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 14) == 0), ($urandom_range(0, 199) == 0), np);
            for (int p = 0; p < np; p++) void'(prog.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: LOAD_LAT, 2, cycles from load issue until its rd is readable (range 1-7).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 q_valid0 / q_valid1  in  1 each  queue head / head+1 entry valid.
REQ-006 q_ins0 / q_ins1  in  32 each  RV32I instruction words at queue head / head+1.
REQ-007 hold  in  1  downstream hold: freeze issue outputs, pop nothing.
REQ-008 flush  in  1  discard the issue registers (taken branch / redirect).
REQ-009 q_pop  out  2  entries consumed this cycle (0, 1, 2), combinational.
REQ-010 dp1_valid, dp1_ins / dp2_valid, dp2_ins  out  1+32 each  registered issue slots for datapaths 1 and 2.
REQ-011 sched_state  out  2  current FSM state (IDLE=0, ISSUE=1, BLOCKED=2).

Function
REQ-012 Decode per slot: rd=[11:7], rs1=[19:15], rs2=[24:20].
REQ-013 uses_rs1: every opcode except LUI, AUIPC, JAL. uses_rs2: R-type, STORE, BRANCH.
REQ-014 writes_rd: R-type, I-ALU, LOAD, LUI, AUIPC, JAL, JALR, and only when rd!=0.
REQ-015 Slot0 issues iff q_valid0, !hold, !flush, and no used source of q_ins0 is busy.
REQ-016 Slot1 dual-issues iff slot0 issues, q_valid1, and no used source of q_ins1 is busy.
REQ-017 Dual issue additionally requires: no RAW (q_ins1 source == q_ins0 rd while q_ins0 writes_rd).
REQ-018 Dual issue additionally requires: no WAW (both write the same rd).
REQ-019 Dual issue additionally requires: not both LOAD/STORE, and q_ins0 not BRANCH/JAL/JALR.
REQ-020 q_pop = number of slots issued in the cycle; q_pop=0 whenever hold or flush is high.
REQ-021 Issue latency is one cycle: an issued word appears on dpN_ins with dpN_valid=1 after the next edge.
REQ-022 A non-issued slot SHALL present valid=0 and ins=32'h0 (NOP) on the next edge.
REQ-023 hold high: dp outputs keep their values; scoreboard keeps counting down.
REQ-024 flush high (priority over hold): both valids and ins clear at the next edge; scoreboard unaffected.
REQ-025 Scoreboard: an issued LOAD with rd!=0 loads a per-register counter with LOAD_LAT, decrementing to 0 each cycle.
REQ-026 A register is busy while its counter is nonzero; x0 is never busy.
REQ-027 Same-cycle set and decrement on one register: the set wins.
REQ-028 FSM: IDLE when !q_valid0; BLOCKED when q_valid0 but slot0 is stalled by the scoreboard; ISSUE otherwise.
REQ-029 hold and flush SHALL NOT change the FSM state.

Reset
REQ-030 On reset: dp1/dp2 valid=0 and ins=0, q_pop=0, all scoreboard counters=0, state=IDLE, stat counters=0.
REQ-031 Reset mid-operation abandons in-flight loads' busy marks; q_pop is forced to 0 during reset.

Configuration
REQ-032 SCHED_STATS_EN defined: adds outputs dual_cnt, split_cnt, stall_cnt (16 bits each, saturating at 16'hFFFF).
REQ-033 dual_cnt counts q_pop=2 cycles, split_cnt counts q_pop=1 cycles with q_valid1=1, stall_cnt counts BLOCKED cycles.
REQ-034 SCHED_STATS_EN undefined: the ports and counters are absent and there is no other behavioural change.

Structure
REQ-035 Shared package sched_pkg SHALL hold the opcode constants, the state enum, and the decoded-fields struct.
REQ-036 The scoreboard SHALL be a sub-module issue_scoreboard (32 counters, 2 set ports, 4 busy-query ports).

Verification
REQ-037 Independent pair: addi x1,x0,5 / addi x2,x0,7 -> q_pop=2, both slots valid next cycle.
REQ-038 RAW pair: addi x1,x0,5 / add x3,x1,x1 -> q_pop=1, dp2_valid=0, then add issues alone next cycle.
REQ-039 Load-use, LOAD_LAT=2: lw x5,0(x0) then add x6,x5,x0 -> state BLOCKED for 2 cycles, then add issues.
REQ-040 Branch in slot0 with addi in slot1 -> q_pop=1; pair of lw/sw -> q_pop=1.
REQ-041 hold high for 3 cycles -> outputs frozen, q_pop=0; flush while holding -> valids=0 next edge.
REQ-042 Reset asserted with a load pending -> all busy cleared; the dependent instruction issues the first cycle after reset deasserts.
